pipe_hazard_ctrl: RTL and testbench

- Control stage directly upstream of the pipeline's register bank (PC, IF/ID, ID/EX, EX/MEM, MEM/WB).
- Produces the per-register load enables and flush controls that those registers consume.
- Resolves three conditions:
  - load-use data hazards (stall plus bubble);
  - taken-branch control hazards (flush);
  - multi-cycle data-memory accesses (full freeze, with a timeout that latches a sticky error).

---
 rtl/pipe_hazard_pkg.sv | 36 +++
 rtl/pipe_hazard_ctrl_if.sv | 43 ++++
 rtl/pipe_hazard_ctrl_lu_cmp.sv | 21 ++
 rtl/pipe_hazard_ctrl.sv | 130 +++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/pipe_hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// The optional stall counter is built only when STALL_CNT_EN is defined.
package pipe_hazard_pkg;

    localparam int          REG_AW_DEF = 5;
    localparam logic [31:0] NOP_INSTR  = 32'h00000013;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR  = 2'd2
    } hz_state_e;

    typedef struct packed {
        logic pc_load;
        logic ifid_load;
        logic ifid_flush;
        logic idex_load;
        logic idex_flush;
        logic exmem_load;
        logic memwb_load;
        logic memwb_flush;
    } hz_ctrl_t;

    function automatic hz_ctrl_t ctrl_all_load();
        hz_ctrl_t c;
        c             = '0;
        c.pc_load     = 1'b1;
        c.ifid_load   = 1'b1;
        c.idex_load   = 1'b1;
        c.exmem_load  = 1'b1;
        c.memwb_load  = 1'b1;
        return c;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-side bundle of the hazard controller: hazard sources in, register controls out.
// master = pipeline datapath, slave = pipe_hazard_ctrl. Signals are level-sampled every cycle; there is no handshake.
interface pipe_hazard_ctrl_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
);
    logic              idex_mem_read;
    logic [REG_AW-1:0] idex_rd;
    logic [REG_AW-1:0] ifid_rs1;
    logic [REG_AW-1:0] ifid_rs2;
    logic              ifid_use_rs1;
    logic              ifid_use_rs2;
    logic              branch_taken;
    logic              dmem_req;
    logic              dmem_ready;

    logic              pc_load;
    logic              ifid_load;
    logic              ifid_flush;
    logic              idex_load;
    logic              idex_flush;
    logic              exmem_load;
    logic              memwb_load;
    logic              memwb_flush;
    logic              mem_err;
    logic [CNT_W-1:0]  stall_cnt;
    logic [1:0]        state_dbg;

    modport master (
        output idex_mem_read, idex_rd, ifid_rs1, ifid_rs2, ifid_use_rs1, ifid_use_rs2,
               branch_taken, dmem_req, dmem_ready,
        input  pc_load, ifid_load, ifid_flush, idex_load, idex_flush, exmem_load,
               memwb_load, memwb_flush, mem_err, stall_cnt, state_dbg
    );

    modport slave (
        input  idex_mem_read, idex_rd, ifid_rs1, ifid_rs2, ifid_use_rs1, ifid_use_rs2,
               branch_taken, dmem_req, dmem_ready,
        output pc_load, ifid_load, ifid_flush, idex_load, idex_flush, exmem_load,
               memwb_load, memwb_flush, mem_err, stall_cnt, state_dbg
    );

endinterface

// File: rtl/pipe_hazard_ctrl_lu_cmp.sv
// Load-use detector: the load in EX writes a register the instruction in ID reads.
module hazard_lu_cmp
    import pipe_hazard_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic              idex_mem_read,
    input  logic [REG_AW-1:0] idex_rd,
    input  logic [REG_AW-1:0] ifid_rs1,
    input  logic [REG_AW-1:0] ifid_rs2,
    input  logic              ifid_use_rs1,
    input  logic              ifid_use_rs2,
    output logic              lu
);

    // x0 is hardwired to zero, so a load targeting it can never feed a consumer.
    assign lu = idex_mem_read && (idex_rd != '0) &&
                ((ifid_use_rs1 && (ifid_rs1 == idex_rd)) ||
                 (ifid_use_rs2 && (ifid_rs2 == idex_rd)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, branch flush, data-memory freeze with timeout.
// Define STALL_CNT_EN to build the saturating stall-cycle counter.
module pipe_hazard_ctrl
    import pipe_hazard_pkg::*;
#(
    parameter int REG_AW  = REG_AW_DEF,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic               clk,
    input  logic               rst,
    pipe_hazard_ctrl_if.slave  hz
);

    localparam int WCW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    hz_state_e      state_q, state_d;
    logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
    logic           mem_err_q, mem_err_d;
    logic           lu, freeze;
    hz_ctrl_t       ctrl;

    hazard_lu_cmp #(.REG_AW(REG_AW)) u_lu_cmp (
        .idex_mem_read (hz.idex_mem_read),
        .idex_rd       (hz.idex_rd),
        .ifid_rs1      (hz.ifid_rs1),
        .ifid_rs2      (hz.ifid_rs2),
        .ifid_use_rs1  (hz.ifid_use_rs1),
        .ifid_use_rs2  (hz.ifid_use_rs2),
        .lu            (lu)
    );

    assign freeze = hz.dmem_req && !hz.dmem_ready;

    // A branch held by a frozen EX stage is flushed in the first cycle after the freeze lifts.
    always_comb begin
        ctrl = '0;
        if (!rst || state_q == ST_ERR) begin
            ctrl = '0;
        end else if (freeze) begin
            ctrl.memwb_load  = 1'b1;
            ctrl.memwb_flush = 1'b1;
        end else if (hz.branch_taken) begin
            ctrl            = ctrl_all_load();
            ctrl.ifid_flush = 1'b1;
            ctrl.idex_flush = 1'b1;
        end else if (lu) begin
            ctrl.idex_load  = 1'b1;
            ctrl.idex_flush = 1'b1;
            ctrl.exmem_load = 1'b1;
            ctrl.memwb_load = 1'b1;
        end else begin
            ctrl = ctrl_all_load();
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        mem_err_d  = mem_err_q;
        case (state_q)
            ST_RUN: begin
                if (freeze) begin
                    state_d    = ST_WAIT;
                    wait_cnt_d = WCW'(1);
                end
            end
            ST_WAIT: begin
                if (!freeze) begin
                    state_d    = ST_RUN;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == WCW'(TIMEOUT - 1)) begin
                    state_d    = ST_ERR;
                    wait_cnt_d = '0;
                    mem_err_d  = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            ST_ERR:  state_d = ST_ERR;
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_RUN;
            wait_cnt_q <= '0;
            mem_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            mem_err_q  <= mem_err_d;
        end
    end

`ifdef STALL_CNT_EN
    logic             stall;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    // Branch flushes are not stalls; only freeze and an unflushed load-use count.
    assign stall = (state_q != ST_ERR) && (freeze || (lu && !hz.branch_taken));

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) stall_cnt_q <= '0;
        else      stall_cnt_q <= stall_cnt_d;
    end

    assign hz.stall_cnt = stall_cnt_q;
`else
    assign hz.stall_cnt = '0;
`endif

    assign hz.pc_load     = ctrl.pc_load;
    assign hz.ifid_load   = ctrl.ifid_load;
    assign hz.ifid_flush  = ctrl.ifid_flush;
    assign hz.idex_load   = ctrl.idex_load;
    assign hz.idex_flush  = ctrl.idex_flush;
    assign hz.exmem_load  = ctrl.exmem_load;
    assign hz.memwb_load  = ctrl.memwb_load;
    assign hz.memwb_flush = ctrl.memwb_flush;
    assign hz.mem_err     = mem_err_q;
    assign hz.state_dbg   = state_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: vector table for the decode, hand sequences for freeze/timeout/reset.
module tb_pipe_hazard_ctrl;

    localparam int REG_AW  = 5;
    localparam int TIMEOUT = 16;
    localparam int CNT_W   = 32;

    // {pc_load, ifid_load, ifid_flush, idex_load, idex_flush, exmem_load, memwb_load, memwb_flush}
    localparam logic [7:0] O_NORM = 8'b1101_0110;
    localparam logic [7:0] O_LU   = 8'b0001_1110;
    localparam logic [7:0] O_BR   = 8'b1111_1110;
    localparam logic [7:0] O_FRZ  = 8'b0000_0011;
    localparam logic [7:0] O_OFF  = 8'b0000_0000;

    localparam logic [1:0] S_RUN  = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_ERR  = 2'd2;

    typedef struct {
        logic       mr;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic       br;
        logic       req;
        logic       rdy;
        logic [7:0] exp_o;
        logic [1:0] exp_st;
    } vec_t;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;
    logic [CNT_W-1:0] exp_stall;
    vec_t vecs[14];

    pipe_hazard_ctrl_if #(.REG_AW(REG_AW), .CNT_W(CNT_W)) hz ();

    pipe_hazard_ctrl #(.REG_AW(REG_AW), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic mr, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic u1, input logic u2,
                         input logic br, input logic req, input logic rdy);
        hz.idex_mem_read = mr;
        hz.idex_rd       = rd;
        hz.ifid_rs1      = rs1;
        hz.ifid_rs2      = rs2;
        hz.ifid_use_rs1  = u1;
        hz.ifid_use_rs2  = u2;
        hz.branch_taken  = br;
        hz.dmem_req      = req;
        hz.dmem_ready    = rdy;
    endtask

    task automatic drive_idle();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic drive_freeze();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic check(input string nm, input logic [7:0] exp_o, input logic exp_err,
                         input logic [1:0] exp_st);
        logic [7:0]       act_o;
        logic [CNT_W-1:0] want_cnt;
        act_o = {hz.pc_load, hz.ifid_load, hz.ifid_flush, hz.idex_load, hz.idex_flush,
                 hz.exmem_load, hz.memwb_load, hz.memwb_flush};
`ifdef STALL_CNT_EN
        want_cnt = exp_stall;
`else
        want_cnt = '0;
`endif
        n_tests++;
        if (act_o !== exp_o) begin
            n_fail++;
            $display("FAIL %s ctrl: got %b want %b", nm, act_o, exp_o);
        end
        n_tests++;
        if (hz.mem_err !== exp_err) begin
            n_fail++;
            $display("FAIL %s mem_err: got %b want %b", nm, hz.mem_err, exp_err);
        end
        n_tests++;
        if (hz.state_dbg !== exp_st) begin
            n_fail++;
            $display("FAIL %s state: got %0d want %0d", nm, hz.state_dbg, exp_st);
        end
        n_tests++;
        if (hz.stall_cnt !== want_cnt) begin
            n_fail++;
            $display("FAIL %s stall_cnt: got %0d want %0d", nm, hz.stall_cnt, want_cnt);
        end
    endtask

    // Advance one clock; inputs are driven and checked between negedges.
    task automatic tick(input logic stalled);
        @(posedge clk);
        if (stalled) exp_stall = exp_stall + 1'b1;
        @(negedge clk);
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        exp_stall = '0;

        //             mr    rd     rs1    rs2    u1    u2    br    req   rdy   expected  state
        vecs[0]  = '{1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_NORM, S_RUN};
        vecs[1]  = '{1'b1, 5'd5,  5'd3,  5'd5,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, O_LU,   S_RUN};
        vecs[2]  = '{1'b1, 5'd0,  5'd0,  5'd0,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, O_NORM, S_RUN};
        vecs[3]  = '{1'b1, 5'd7,  5'd7,  5'd2,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, O_LU,   S_RUN};
        vecs[4]  = '{1'b1, 5'd7,  5'd7,  5'd2,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, O_NORM, S_RUN};
        vecs[5]  = '{1'b0, 5'd7,  5'd7,  5'd7,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, O_NORM, S_RUN};
        vecs[6]  = '{1'b1, 5'd5,  5'd5,  5'd5,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, O_BR,   S_RUN};
        vecs[7]  = '{1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, O_BR,   S_RUN};
        vecs[8]  = '{1'b1, 5'd5,  5'd5,  5'd0,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, O_FRZ,  S_RUN};
        vecs[9]  = '{1'b1, 5'd5,  5'd5,  5'd0,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1, O_LU,   S_WAIT};
        vecs[10] = '{1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, O_FRZ,  S_RUN};
        vecs[11] = '{1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, O_BR,   S_WAIT};
        vecs[12] = '{1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, O_NORM, S_RUN};
        vecs[13] = '{1'b1, 5'd31, 5'd0,  5'd31, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, O_LU,   S_RUN};

        // Reset held with every input high.
        rst = 1'b0;
        drive(1'b1, 5'd31, 5'd31, 5'd31, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        @(negedge clk);
        check("reset", O_OFF, 1'b0, S_RUN);
        rst = 1'b1;
        drive_idle();
        #1 check("release", O_NORM, 1'b0, S_RUN);
        tick(1'b0);

        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].mr, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].u1, vecs[i].u2,
                  vecs[i].br, vecs[i].req, vecs[i].rdy);
            #1 check($sformatf("vec%0d", i), vecs[i].exp_o, 1'b0, vecs[i].exp_st);
            tick((vecs[i].exp_o == O_LU) || (vecs[i].exp_o == O_FRZ));
        end

        // Three-cycle freeze, then ready.
        for (int i = 0; i < 3; i++) begin
            drive_freeze();
            #1 check($sformatf("frz3_%0d", i), O_FRZ, 1'b0, (i == 0) ? S_RUN : S_WAIT);
            tick(1'b1);
        end
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        #1 check("frz3_done", O_NORM, 1'b0, S_WAIT);
        tick(1'b0);

        // TIMEOUT-1 freeze cycles complete without error.
        for (int i = 0; i < TIMEOUT - 1; i++) begin
            drive_freeze();
            #1;
            if (i == 0 || i == TIMEOUT - 2)
                check($sformatf("frz15_%0d", i), O_FRZ, 1'b0, (i == 0) ? S_RUN : S_WAIT);
            tick(1'b1);
        end
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        #1 check("frz15_done", O_NORM, 1'b0, S_WAIT);
        tick(1'b0);
        drive_idle();
        #1 check("frz15_idle", O_NORM, 1'b0, S_RUN);
        tick(1'b0);

        // TIMEOUT freeze cycles latch the error.
        for (int i = 0; i < TIMEOUT; i++) begin
            drive_freeze();
            #1;
            if (i == 0 || i == TIMEOUT - 1)
                check($sformatf("frz16_%0d", i), O_FRZ, 1'b0, (i == 0) ? S_RUN : S_WAIT);
            tick(1'b1);
        end
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        #1 check("err_ready", O_OFF, 1'b1, S_ERR);
        tick(1'b0);
        drive_idle();
        #1 check("err_sticky", O_OFF, 1'b1, S_ERR);
        #1 rst = 1'b0;
        exp_stall = '0;
        #1 check("err_rst", O_OFF, 1'b0, S_RUN);
        @(negedge clk);
        rst = 1'b1;
        #1 check("err_release", O_NORM, 1'b0, S_RUN);
        tick(1'b0);

        // Asynchronous reset in the middle of a freeze.
        for (int i = 0; i < 2; i++) begin
            drive_freeze();
            tick(1'b1);
        end
        drive_freeze();
        #1 check("wait_pre", O_FRZ, 1'b0, S_WAIT);
        #2 rst = 1'b0;
        exp_stall = '0;
        #1 check("wait_rst", O_OFF, 1'b0, S_RUN);
        @(negedge clk);
        rst = 1'b1;
        drive_idle();
        #1 check("wait_release", O_NORM, 1'b0, S_RUN);
        tick(1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
